hello_req_driver: RTL
=====================

# hello_req_driver

Upstream driver for `mod_hello`-style request/acknowledge endpoints. On a start pulse it runs a programmable number of four-phase `req_hello`/`ack_hello` handshakes back-to-back, counts the completed ones, and reports completion or timeout. It sits between the controller's start/done interface and the endpoint's req/ack pair.

## Interface
Parameters:
- `CNT_W`, 8: width of the handshake count and the completed count.
- `TIMEOUT`, 15: maximum number of cycles spent waiting in one handshake phase; must be at least 1.
- `TO_W`, 4: width of the timeout counter; must satisfy `TIMEOUT` < 2^`TO_W`.

Ports:
- `clk`, input, 1: the only clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: begin a sequence; sampled only in IDLE, ignored otherwise.
- `num_req`, input, `CNT_W`: number of handshakes; latched when `start` is accepted.
- `req_hello`, output, 1: registered request to the endpoint.
- `ack_hello`, input, 1: acknowledge from the endpoint.
- `busy`, output, 1: high in REQ and RELEASE.
- `done`, output, 1: one-cycle pulse when a sequence ends, on success or on timeout.
- `err`, output, 1: sticky timeout flag; cleared when the next `start` is accepted.
- `issued`, output, `CNT_W`: handshakes completed in the current or last sequence.

## Operation
- States: IDLE, REQ, RELEASE. `req_hello` = (state == REQ), taken from a register; no combinational path from any input to any output.
- IDLE, `start`=1, `num_req`≠0: latch `num_req`, clear `issued`, `err` and the timeout counter, then go to REQ.
- IDLE, `start`=1, `num_req`=0: pulse `done` next cycle, clear `issued` and `err`, stay in IDLE. `req_hello` never rises.
- REQ, `ack_hello`=1: `issued`++, clear the timeout counter, go to RELEASE.
- RELEASE, `ack_hello`=0:
  - if `issued` equals the latched count: pulse `done`, go to IDLE;
  - otherwise: clear the timeout counter, go to REQ.
- Timeout: in REQ or RELEASE, the timeout counter increments on every cycle the awaited level is absent. When it reaches `TIMEOUT` the block sets `err`, pulses `done` and goes to IDLE, which drops `req_hello`. `issued` keeps its value.
- `issued` saturates at 2^`CNT_W`−1 and never wraps; it cannot exceed the latched count.
- `start` asserted in REQ or RELEASE has no effect.
- Reset, including in mid-sequence: state goes to IDLE and `req_hello` drops immediately. All outputs reset to 0: `req_hello`, `busy`, `done`, `err`, `issued`.

## Timing
- `start` accepted in cycle t: `req_hello` and `busy` are high from cycle t+1.
- Against an endpoint that echoes `req` as `ack` one cycle later (the `mod_hello` behaviour), each handshake takes 4 cycles:
  - `req_hello` is high in cycles t+1 and t+2, then t+5 and t+6, and so on;
  - `issued` first reads 1 in cycle t+3;
  - `done` pulses in cycle t+4N+1, the same cycle `busy` falls.
- Timeout: `done` and `err` rise `TIMEOUT`+1 cycles after the phase is entered. `req_hello` is low in the same cycle.
- A new `start` can be accepted in the cycle that `done` is high, because the state is already IDLE.

## Structure
- Shared package/header holds:
  - state encoding constants `HS_IDLE`=0, `HS_REQ`=1, `HS_RELEASE`=2 (2-bit);
  - the parameter legality check `TIMEOUT` < 2^`TO_W`.
- Sub-module `hs_timeout_ctr` (clear, enable, expired; parameters `TIMEOUT`, `TO_W`). It is reused by the other request drivers.
- The FSM, the count latch and the saturating `issued` counter live in the top module.

## Test plan
- `num_req`=3, `start` in cycle 0, echo endpoint → `req_hello` high in cycles 1–2, 5–6 and 9–10; `done` in cycle 13; `issued`=3; `err`=0.
- `num_req`=0, `start` → `done` in cycle 1; `req_hello` and `busy` never rise; `issued`=0.
- `ack_hello` tied to 0, `num_req`=2, `TIMEOUT`=15 → `done` and `err` in cycle 17, `req_hello` low in cycle 17, `issued`=0. A following `start` clears `err`.
- `ack_hello` stuck at 1 after the first handshake, `num_req`=2 → RELEASE times out; `err`=1, `issued`=1.
- `start` pulsed again in cycle 3 of a `num_req`=2 sequence → ignored; `issued` ends at 2 with a single `done`.
- `rst_n` low in cycle 6 of a `num_req`=5 sequence → `req_hello`, `busy` and `issued` go to 0 at once; after release the block sits in IDLE and accepts a new `start`.

Source files
------------

// File: rtl/hello_req_driver_pkg.sv
// Shared types and parameter checks for the hello request drivers.
package hello_req_driver_pkg;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_REQ     = 2'd1,
    HS_RELEASE = 2'd2
  } hs_state_e;

  // The timeout counter must be able to hold TIMEOUT, and TIMEOUT must be non-zero.
  function automatic bit timeout_params_ok(int unsigned timeout, int unsigned to_w);
    return (timeout >= 1) && (to_w >= 1) && (to_w < 32) && (timeout < (32'd1 << to_w));
  endfunction

endpackage

// File: rtl/hs_timeout_ctr.sv
// Per-phase wait counter: cleared on phase entry, counts while the awaited level is absent.
module hs_timeout_ctr
  import hello_req_driver_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (!timeout_params_ok(TIMEOUT, TO_W)) begin : g_param_check
    $error("hs_timeout_ctr: TIMEOUT must be in 1 .. 2**TO_W-1");
  end

  localparam logic [TO_W-1:0] Limit = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Saturates at Limit so expired stays asserted until the next clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != Limit)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == Limit);

endmodule

// File: rtl/hello_req_driver.sv
// Runs a programmed number of four-phase req/ack handshakes and reports done/timeout.
module hello_req_driver
  import hello_req_driver_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_req,
  output logic             req_hello,
  input  logic             ack_hello,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] issued
);

  hs_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             tmo_clear, tmo_enable, tmo_expired;

  hs_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    issued_d   = issued_q;
    err_d      = err_q;
    done_d     = 1'b0;
    tmo_clear  = 1'b0;
    tmo_enable = 1'b0;

    case (state_q)
      HS_IDLE: begin
        if (start) begin
          issued_d  = '0;
          err_d     = 1'b0;
          tmo_clear = 1'b1;
          if (num_req == '0) begin
            done_d = 1'b1;
          end else begin
            count_d = num_req;
            state_d = HS_REQ;
          end
        end
      end

      // An ack arriving in the expiry cycle still counts as progress.
      HS_REQ: begin
        if (ack_hello) begin
          if (issued_q != '1) begin
            issued_d = issued_q + CNT_W'(1);
          end
          tmo_clear = 1'b1;
          state_d   = HS_RELEASE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = HS_IDLE;
        end else begin
          tmo_enable = 1'b1;
        end
      end

      HS_RELEASE: begin
        if (!ack_hello) begin
          if (issued_q == count_q) begin
            done_d  = 1'b1;
            state_d = HS_IDLE;
          end else begin
            tmo_clear = 1'b1;
            state_d   = HS_REQ;
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = HS_IDLE;
        end else begin
          tmo_enable = 1'b1;
        end
      end

      default: state_d = HS_IDLE;
    endcase

    req_d  = (state_d == HS_REQ);
    busy_d = (state_d != HS_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HS_IDLE;
      count_q  <= '0;
      issued_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      err_q    <= err_d;
      done_q   <= done_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
    end
  end

  assign req_hello = req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign issued    = issued_q;

endmodule
